// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the multi-channel button debouncer.
// Defaults assume a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } hold_state_t;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;
    localparam int DEF_CNT_W           = 26;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when a cnt_w-bit counter can hold every timing constant (2^cnt_w > max).
    function automatic bit cnt_w_fits(input int cnt_w, input int a, input int b, input int c);
        return cnt_w >= $clog2(max3(a, b, c) + 1);
    endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce counter, hold FSM and
// registered press/release/long/repeat pulses.
module button_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_db_cnt;

    hold_state_t      r_state;
    hold_state_t      w_state_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;

    logic r_press, r_release, r_long, r_repeat;
    logic w_press, w_release, w_long, w_repeat;

    // Comparisons use >= so a counter can never run past its threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (r_s2 != r_stable) begin
                if (r_db_cnt >= DB_LAST) begin
                    r_stable <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_press    <= w_press;
            r_release  <= w_release;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
        end
    end

    // While not IDLE the FSM tracks a high stable level, so edges follow from state.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (r_stable) begin
                    w_state_next    = PRESSED;
                    w_hold_cnt_next = '0;
                end
            end
            PRESSED: begin
                if (!r_stable) begin
                    w_state_next    = IDLE;
                    w_hold_cnt_next = '0;
                end else if (r_hold_cnt >= LONG_LAST) begin
                    w_state_next    = HELD;
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_stable) begin
                    w_state_next    = IDLE;
                    w_hold_cnt_next = '0;
                end else if (!i_repeat_en || (r_hold_cnt >= REP_LAST)) begin
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    // Release is tested first in both held states, so it wins over a coincident threshold.
    always_comb begin
        w_press   = 1'b0;
        w_release = 1'b0;
        w_long    = 1'b0;
        w_repeat  = 1'b0;
        case (r_state)
            IDLE:    w_press = r_stable;
            PRESSED: begin
                w_release = !r_stable;
                w_long    = r_stable && (r_hold_cnt >= LONG_LAST);
            end
            HELD: begin
                w_release = !r_stable;
                w_repeat  = r_stable && i_repeat_en && (r_hold_cnt >= REP_LAST);
            end
            default: ;
        endcase
    end

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_debounce_multi.sv
// N_BTN independent debounced button channels plus a registered any-event flag
// for the wave-generator control FSM.
module button_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_event
);

    logic r_any_event;

    if (!cnt_w_fits(CNT_W, DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too small for DEBOUNCE/LONG/REPEAT cycle counts");
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            button_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .i_btn       (btn_in[gi]),
                .i_repeat_en (repeat_en[gi]),
                .o_level     (btn_level[gi]),
                .o_press     (press_pulse[gi]),
                .o_release   (release_pulse[gi]),
                .o_long      (long_pulse[gi]),
                .o_repeat    (repeat_pulse[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_event <= 1'b0;
        end else begin
            r_any_event <= |{press_pulse, release_pulse, long_pulse, repeat_pulse};
        end
    end

    assign any_event = r_any_event;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi with short timing constants
// (debounce 4, long 20, repeat 5, two channels).
module tb_button_debounce_multi;

    localparam int N_BTN = 2;
    localparam int MAXC  = 64;
    localparam logic [3:0] P_PRESS = 4'b0001;
    localparam logic [3:0] P_REL   = 4'b0010;
    localparam logic [3:0] P_LONG  = 4'b0100;
    localparam logic [3:0] P_REP   = 4'b1000;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] repeat_en;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    logic             any_event;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       btn;
        logic       lvl;
        logic [3:0] pls;
        logic       any;
    } vec_t;

    vec_t vecs [0:31];

    // Expected per-edge pulse codes {repeat,long,release,press} and levels, index = edge number.
    logic [3:0] exp_p [0:1][0:MAXC-1];
    logic       exp_l [0:1][0:MAXC-1];
    int         on_t  [0:1];
    int         off_t [0:1];

    button_debounce_multi #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .repeat_en     (repeat_en),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_event     (any_event)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    function automatic logic [7:0] all_outs();
        return {press_pulse, release_pulse, long_pulse, repeat_pulse} | 8'(btn_level) | 8'(any_event);
    endfunction

    task automatic clear_exp();
        for (int c = 0; c < 2; c++) begin
            for (int e = 0; e < MAXC; e++) begin
                exp_p[c][e] = 4'b0;
                exp_l[c][e] = 1'b0;
            end
            on_t[c]  = 999;
            off_t[c] = 999;
        end
    endtask

    task automatic set_lvl(input int c, input int first, input int last);
        for (int e = first; e <= last; e++) exp_l[c][e] = 1'b1;
    endtask

    task automatic run_scn(input string name, input int ncyc);
        int e;
        for (int t = 0; t < ncyc; t++) begin
            for (int c = 0; c < 2; c++) btn_in[c] = (t >= on_t[c]) && (t < off_t[c]);
            tick();
            e = t + 1;
            for (int c = 0; c < 2; c++) begin
                check({name, "_lvl"}, e, 8'(btn_level[c]), 8'(exp_l[c][e]));
                check({name, "_pulse"}, e,
                      8'({repeat_pulse[c], long_pulse[c], release_pulse[c], press_pulse[c]}),
                      8'(exp_p[c][e]));
            end
            check({name, "_any"}, e, 8'(any_event),
                  8'((|exp_p[0][e-1]) | (|exp_p[1][e-1])));
        end
        $display("scenario %s: %0d cycles, %0d/%0d checks so far", name, ncyc, n_pass, n_checks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: glitch rejection (rows 0-9) then clean 12-cycle press (rows 10-31).
        for (int i = 0; i < 32; i++) vecs[i] = '{btn: 1'b0, lvl: 1'b0, pls: 4'b0, any: 1'b0};
        for (int i = 0; i < 3; i++)   vecs[i].btn = 1'b1;
        for (int i = 10; i < 22; i++) vecs[i].btn = 1'b1;
        for (int i = 15; i < 27; i++) vecs[i].lvl = 1'b1;
        vecs[16].pls = P_PRESS;
        vecs[17].any = 1'b1;
        vecs[28].pls = P_REL;
        vecs[29].any = 1'b1;

        rst       = 1'b1;
        btn_in    = '0;
        repeat_en = '0;
        #1;
        check("reset_async", 0, all_outs(), 8'h00);
        tick();
        tick();
        check("reset_held", 0, all_outs(), 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            btn_in    = {1'b0, vecs[i].btn};
            repeat_en = 2'b00;
            tick();
            check("tbl_lvl0", i, 8'(btn_level[0]), 8'(vecs[i].lvl));
            check("tbl_pulse0", i,
                  8'({repeat_pulse[0], long_pulse[0], release_pulse[0], press_pulse[0]}),
                  8'(vecs[i].pls));
            check("tbl_any", i, 8'(any_event), 8'(vecs[i].any));
            check("tbl_ch1", i,
                  8'({btn_level[1], repeat_pulse[1], long_pulse[1], release_pulse[1], press_pulse[1]}),
                  8'h00);
        end
        $display("table vectors: %0d/%0d checks so far", n_pass, n_checks);

        // Long press with repeat; the 4th repeat coincides with release and is suppressed.
        clear_exp();
        repeat_en = 2'b01;
        on_t[0] = 0; off_t[0] = 40;
        set_lvl(0, 6, 45);
        exp_p[0][7]  = P_PRESS;
        exp_p[0][27] = P_LONG;
        exp_p[0][32] = P_REP;
        exp_p[0][37] = P_REP;
        exp_p[0][42] = P_REP;
        exp_p[0][47] = P_REL;
        run_scn("long_repeat", 56);

        // Same hold with repeat disabled.
        clear_exp();
        repeat_en = 2'b00;
        on_t[0] = 0; off_t[0] = 40;
        set_lvl(0, 6, 45);
        exp_p[0][7]  = P_PRESS;
        exp_p[0][27] = P_LONG;
        exp_p[0][47] = P_REL;
        run_scn("no_repeat", 52);

        // Ch0 release lands on the long threshold; ch1 runs its own hold concurrently.
        clear_exp();
        repeat_en = 2'b11;
        on_t[0] = 0; off_t[0] = 20;
        on_t[1] = 2; off_t[1] = 36;
        set_lvl(0, 6, 25);
        exp_p[0][7]  = P_PRESS;
        exp_p[0][27] = P_REL;
        set_lvl(1, 8, 41);
        exp_p[1][9]  = P_PRESS;
        exp_p[1][29] = P_LONG;
        exp_p[1][34] = P_REP;
        exp_p[1][39] = P_REP;
        exp_p[1][43] = P_REL;
        run_scn("coincide", 50);

        // Reach HELD, then reset mid-hold with the button still down.
        clear_exp();
        repeat_en = 2'b01;
        on_t[0] = 0; off_t[0] = 999;
        set_lvl(0, 6, 30);
        exp_p[0][7]  = P_PRESS;
        exp_p[0][27] = P_LONG;
        run_scn("pre_reset", 30);
        #3;
        rst = 1'b1;
        #1;
        check("midhold_rst_async", 0, all_outs(), 8'h00);
        tick();
        check("midhold_rst_1", 1, all_outs(), 8'h00);
        tick();
        check("midhold_rst_2", 2, all_outs(), 8'h00);
        rst = 1'b0;

        clear_exp();
        on_t[0] = 0; off_t[0] = 10;
        set_lvl(0, 6, 15);
        exp_p[0][7]  = P_PRESS;
        exp_p[0][17] = P_REL;
        run_scn("post_reset", 22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
Parametrised multi-channel successor to the single-button debouncer. It synchronises and debounces N_BTN raw push-button inputs and, per channel, produces the debounced level plus single-cycle pulses for press, release, long-press and auto-repeat. It sits between the board pins and the wave-generator control FSM, so that frequency and amplitude stepping can use hold-to-repeat.

Parameters:
N_BTN, 5, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive disagreeing samples required to flip the debounced level (10 ms at 100 MHz)
LONG_CYCLES, 50000000, cycles from press_pulse to long_pulse (0.5 s)
REPEAT_CYCLES, 10000000, repeat_pulse period after long_pulse (0.1 s)
CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES), checked at elaboration

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_in  in  N_BTN  raw asynchronous button inputs, active-high
repeat_en  in  N_BTN  per-channel auto-repeat enable, synchronous to clk
btn_level  out  N_BTN  debounced level
press_pulse  out  N_BTN  one-cycle pulse on debounced rising edge
release_pulse  out  N_BTN  one-cycle pulse on debounced falling edge
long_pulse  out  N_BTN  one-cycle pulse when the hold reaches LONG_CYCLES
repeat_pulse  out  N_BTN  one-cycle pulse every REPEAT_CYCLES while held past long and repeat_en=1
any_event  out  1  registered OR of all pulse outputs of all channels

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, all flops are cleared, including synchronisers, counters and FSMs. All outputs are 0 in reset. Reset deassertion generates no pulses.
- Channels are fully independent; no shared state except any_event.
- Synchroniser: 2-flop chain per bit, reset value 0.
- Debounce: counter db_cnt compares sync output s2 with stable.
  - s2 != stable: db_cnt increments.
  - On the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, stable <= s2 and db_cnt <= 0.
  - s2 == stable: db_cnt <= 0. Any single agreeing sample restarts the count.
- btn_level = stable, driven directly from the flop.
- Latency: press_pulse is high for exactly the cycle after the (DEBOUNCE_CYCLES+3)-th rising edge of clk after btn_in settles high. This breaks down as 2 synchroniser stages + DEBOUNCE_CYCLES + 1 output register. Release has the same latency.
- Hold FSM per channel, states IDLE, PRESSED, HELD; counter hold_cnt.
  - IDLE: on stable rising edge -> PRESSED, hold_cnt <= 0, press_pulse.
  - PRESSED: hold_cnt increments. When hold_cnt reaches LONG_CYCLES-1 -> HELD, hold_cnt <= 0, long_pulse. long_pulse is therefore exactly LONG_CYCLES cycles after press_pulse.
  - HELD, repeat_en=1: hold_cnt increments. At REPEAT_CYCLES-1, repeat_pulse and hold_cnt <= 0.
  - HELD, repeat_en=0: hold_cnt held at 0, no repeat pulses. Re-enabling starts a full REPEAT_CYCLES period.
  - PRESSED or HELD, on stable falling edge -> IDLE, hold_cnt <= 0, release_pulse.
- Simultaneous events: a stable fall in the same cycle as a long or repeat threshold means release wins; no long_pulse or repeat_pulse is emitted.
- Pulse exclusivity: at most one of the four pulse outputs is high per channel per cycle.
- All pulse outputs are registered.
- any_event is registered one cycle after the pulses.
- Counters saturate; they never wrap. db_cnt cannot exceed DEBOUNCE_CYCLES-1.
- Reset mid-hold returns the channel to IDLE with no release_pulse. If the button is still held after reset release, a fresh press_pulse follows after the normal debounce latency.

Decomposition:
- Shared package btn_pkg:
  - hold-state enum (IDLE, PRESSED, HELD)
  - clog2-based helper for CNT_W checking
  - default timing constants for 100 MHz
- Sub-module button_debounce_chan: one channel (synchroniser, debounce, hold FSM, pulse registers). The top instantiates it N_BTN times via generate and builds any_event.

Test Plan:
Bench parameters: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
1. Glitch rejection: btn_in[0] high for 3 cycles, then low -> btn_level[0] stays 0; no pulses at all.
2. Clean press/release: btn_in[0] rises, held 12 cycles, then falls -> press_pulse[0] in the single cycle after the 7th edge; btn_level high; release_pulse[0] one cycle, 12 cycles later; no long_pulse.
3. Long press with repeat (repeat_en[0]=1): hold 40 cycles -> long_pulse at press+20; repeat_pulse at press+25, +30, +35, continuing until the debounced release; release_pulse once.
4. Repeat disabled: same stimulus as scenario 3 with repeat_en=0 -> long_pulse at press+20, zero repeat_pulse.
5. Simultaneous/independent: debounced release arranged to coincide with the long threshold -> only release_pulse. Channel 1 is pressed concurrently, and its pulses are unaffected by channel 0.
6. Reset mid-hold: assert rst in HELD state -> all outputs 0 immediately with no release_pulse. Keep btn_in high and deassert rst -> press_pulse after 7 edges.
